mul_div_unit: RTL and testbench

Multi-cycle execution unit for the 8051 `MUL AB` and `DIV AB` instructions. It produces the results that the processing stage returns for the reserved ALU opcode `4'hf`, and sits beside the single-cycle ALU. The CPU control starts it with a one-cycle pulse and waits on `busy`. It then takes `a_out`, `b_out` and `psw_out` as the new A, B and PSW when `done` pulses.

---
 rtl/mul_div_unit.sv | 139 +++++++++++++
 tb/tb_mul_div_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle MUL AB / DIV AB unit: shift-add multiply and restoring divide,
// one step per clock.
//
// Handshake: start is a one-cycle request, accepted on any edge where the unit
// is IDLE or in its final DONE cycle. busy is high from the accepting edge
// until the unit returns to IDLE. done pulses for one cycle and the results
// are valid during that cycle. The results then hold until the next
// operation completes.
module mul_div_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       op,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  input  logic [7:0] psw_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] a_out,
  output logic [7:0] b_out,
  output logic [7:0] psw_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic        op_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [7:0]  psw_q;
  logic [2:0]  cnt;
  logic [15:0] prod;
  logic [7:0]  rem;
  logic [7:0]  quo;

  logic [15:0] prod_nxt;
  logic [8:0]  rem_sh;
  logic [7:0]  rem_nxt;
  logic [7:0]  quo_nxt;
  logic [7:0]  res_a;
  logic [7:0]  res_b;
  logic        res_ov;
  logic [7:0]  psw_calc;

  always_comb begin
    prod_nxt = prod;
    if (b_q[cnt]) prod_nxt = prod + ({8'd0, a_q} << cnt);

    // The remainder after a subtract is below the divisor, so 8 bits hold it.
    rem_sh = {rem, a_q[3'd7 - cnt]};
    if (rem_sh >= {1'b0, b_q}) begin
      rem_nxt = rem_sh[7:0] - b_q;
      quo_nxt = {quo[6:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[7:0];
      quo_nxt = {quo[6:0], 1'b0};
    end

    if (op_q) begin
      res_a  = quo_nxt;
      res_b  = rem_nxt;
      res_ov = 1'b0;
    end else begin
      res_a  = prod_nxt[7:0];
      res_b  = prod_nxt[15:8];
      res_ov = |prod_nxt[15:8];
    end

    // CY and OV and P are rewritten; every other PSW bit passes through.
    psw_calc = (psw_q & 8'h7a) | {5'd0, res_ov, 1'b0, ^res_a};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      a_out   <= 8'd0;
      b_out   <= 8'd0;
      psw_out <= 8'd0;
      op_q    <= 1'b0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      psw_q   <= 8'd0;
      cnt     <= 3'd0;
      prod    <= 16'd0;
      rem     <= 8'd0;
      quo     <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        CALC: begin
          prod <= prod_nxt;
          rem  <= rem_nxt;
          quo  <= quo_nxt;
          cnt  <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state   <= DONE;
            done    <= 1'b1;
            a_out   <= res_a;
            b_out   <= res_b;
            psw_out <= psw_calc;
          end
        end
        default: begin
          // IDLE and the DONE cycle both accept a new request.
          if (start) begin
            op_q  <= op;
            a_q   <= a_in;
            b_q   <= b_in;
            psw_q <= psw_in;
            cnt   <= 3'd0;
            prod  <= 16'd0;
            rem   <= 8'd0;
            quo   <= 8'd0;
            busy  <= 1'b1;
            if (op && (b_in == 8'd0)) begin
              state   <= DONE;
              done    <= 1'b1;
              a_out   <= 8'hff;
              b_out   <= a_in;
              psw_out <= (psw_in & 8'h7a) | 8'h04;
            end else begin
              state <= CALC;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: vector table plus random operations through a
// scoreboard queue, and hand-written busy/reset/back-to-back sequences.
module tb_mul_div_unit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       op;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic [7:0] psw_in;
  logic       busy;
  logic       done;
  logic [7:0] a_out;
  logic [7:0] b_out;
  logic [7:0] psw_out;

  int tests_run = 0;
  int fails = 0;

  logic [23:0] exp_q[$];

  typedef struct {
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] psw;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic [7:0] exp_psw;
    int         lat;
  } vec_t;

  vec_t vecs[7];

  mul_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in), .psw_in(psw_in),
    .busy(busy), .done(done), .a_out(a_out), .b_out(b_out), .psw_out(psw_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] model(input logic o, input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] psw);
    logic [15:0] p;
    logic [7:0]  ra, rb;
    logic        ov;
    if (!o) begin
      p  = a * b;
      ra = p[7:0];
      rb = p[15:8];
      ov = (p > 16'd255);
    end else if (b == 8'd0) begin
      ra = 8'hff;
      rb = a;
      ov = 1'b1;
    end else begin
      ra = a / b;
      rb = a % b;
      ov = 1'b0;
    end
    return {ra, rb, 1'b0, psw[6:3], ov, psw[1], ^ra};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge: drives one request, returns at the next negedge.
  task automatic issue(input logic o, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] psw, input logic [23:0] exp);
    start  = 1'b1;
    op     = o;
    a_in   = a;
    b_in   = b;
    psw_in = psw;
    exp_q.push_back(exp);
    @(negedge clk);
    start  = 1'b0;
    op     = 1'($urandom_range(0, 1));
    a_in   = 8'($urandom_range(0, 255));
    b_in   = 8'($urandom_range(0, 255));
    psw_in = 8'($urandom_range(0, 255));
  endtask

  // Called at the first negedge after acceptance; returns at the done negedge.
  task automatic wait_done(input int lat, input bit noise, input string name);
    int n;
    n = 1;
    while (!done && n < 20) begin
      start = noise && (n == 3 || n == 8);
      if (start) begin
        op     = 1'($urandom_range(0, 1));
        a_in   = 8'($urandom_range(0, 255));
        b_in   = 8'($urandom_range(1, 255));
        psw_in = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({name, "_latency"}, n, lat);
    check({name, "_busy_at_done"}, busy, 1'b1);
  endtask

  task automatic run_op(input logic o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] psw, input logic [23:0] exp, input int lat,
                        input string name);
    @(negedge clk);
    issue(o, a, b, psw, exp);
    check({name, "_busy"}, busy, 1'b1);
    wait_done(lat, 1'b0, name);
    @(negedge clk);
    check({name, "_busy_drop"}, busy, 1'b0);
    check({name, "_done_drop"}, done, 1'b0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [23:0] e;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", done, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("a_out", a_out, e[23:16]);
        check("b_out", b_out, e[15:8]);
        check("psw_out", psw_out, e[7:0]);
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{1'b0, 8'h50, 8'ha0, 8'h00, 8'h00, 8'h32, 8'h04, 9};
    vecs[1] = '{1'b0, 8'h02, 8'h03, 8'hff, 8'h06, 8'h00, 8'h7a, 9};
    vecs[2] = '{1'b1, 8'hfb, 8'h12, 8'h00, 8'h0d, 8'h11, 8'h01, 9};
    vecs[3] = '{1'b1, 8'h07, 8'h09, 8'h00, 8'h00, 8'h07, 8'h00, 9};
    vecs[4] = '{1'b1, 8'h55, 8'h00, 8'h00, 8'hff, 8'h55, 8'h04, 1};
    vecs[5] = '{1'b0, 8'hff, 8'hff, 8'h00, 8'h01, 8'hfe, 8'h05, 9};
    vecs[6] = '{1'b1, 8'h64, 8'h07, 8'hc0, 8'h0e, 8'h02, 8'h41, 9};

    rst_n = 1'b0; start = 1'b0; op = 1'b0;
    a_in = 8'd0; b_in = 8'd0; psw_in = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_a", a_out, 8'h00);
    check("rst_b", b_out, 8'h00);
    check("rst_psw", psw_out, 8'h00);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].psw,
             {vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_psw}, vecs[i].lat, $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      logic       o;
      logic [7:0] a, b, p;
      o = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 255));
      b = (i % 7 == 6) ? 8'd0 : 8'($urandom_range(0, 255));
      p = 8'($urandom_range(0, 255));
      run_op(o, a, b, p, model(o, a, b, p), (o && b == 8'd0) ? 1 : 9, $sformatf("rnd%0d", i));
    end

    // starts during CALC are ignored
    @(negedge clk);
    issue(1'b0, 8'h50, 8'ha0, 8'h00, 24'h003204);
    wait_done(9, 1'b1, "ignore");
    // start in the DONE cycle is accepted back-to-back
    issue(1'b1, 8'hfb, 8'h12, 8'h00, 24'h0d1101);
    check("b2b_busy", busy, 1'b1);
    check("b2b_done_low", done, 1'b0);
    wait_done(9, 1'b0, "b2b");
    // divide-by-zero back-to-back into another divide-by-zero
    issue(1'b1, 8'h33, 8'h00, 8'h80, 24'hff3304);
    wait_done(1, 1'b0, "b2b_dz");
    issue(1'b0, 8'h10, 8'h10, 8'h00, 24'h000104);
    wait_done(9, 1'b0, "b2b_mul");
    @(negedge clk);
    check("b2b_busy_drop", busy, 1'b0);

    // reset mid-CALC aborts without a done pulse
    @(negedge clk);
    issue(1'b0, 8'hff, 8'hff, 8'hff, 24'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_a", a_out, 8'h00);
    check("midrst_b", b_out, 8'h00);
    check("midrst_psw", psw_out, 8'h00);
    repeat (12) @(negedge clk);
    check("midrst_idle", busy, 1'b0);
    run_op(1'b0, 8'h02, 8'h03, 8'hff, 24'h06007a, 9, "post_rst");

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
